// File: rtl/simd_msg_feeder.sv
// simd_msg_feeder: feeds a 16-bit message stream into the SIMD-256 hash
// wrapper (init / load / zero pad / length block) and streams the digest out.
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   s_data/s_keep/s_last/s_valid/s_ready   message word input stream
//   core_init/core_load/core_fetch/core_idata  requests to the wrapper
//   core_ack/core_odata                wrapper acknowledge and digest word
//   m_data/m_valid/m_last/m_ready      16-word digest output stream
//   busy, err                          message in flight, sticky ack timeout
// Parameter ACK_TIMEOUT: request cycles without ack before err (0 = off).
// Macro SIMD_FEED_DIGEST_BUF_EN: buffer all 16 digest words before output;
// otherwise each fetch waits for the previous word to leave downstream.

module simd_msg_feeder #(
    parameter int ACK_TIMEOUT = 4095
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] s_data,
    input  logic [1:0]  s_keep,
    input  logic        s_last,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        core_init,
    output logic        core_load,
    output logic        core_fetch,
    output logic [15:0] core_idata,
    input  logic        core_ack,
    input  logic [15:0] core_odata,
    output logic [15:0] m_data,
    output logic        m_valid,
    output logic        m_last,
    input  logic        m_ready,
    output logic        busy,
    output logic        err
);

    typedef enum logic [3:0] {
        IDLE, INIT, ACCEPT, LOAD, GAP, PAD, LEN, FETCH, FGAP, OUT
    } state_t;

    // Which dispatch state a LOAD/GAP pair returns to.
    typedef enum logic [1:0] {
        SRC_DATA, SRC_PAD, SRC_LEN
    } src_t;

    state_t      state, state_n;
    src_t        src, src_n;
    logic [63:0] bitlen, bitlen_n;
    logic [4:0]  wcnt, wcnt_n;
    logic [3:0]  dcnt, dcnt_n;
    logic [3:0]  dnext;
    logic        last, last_n;
    logic [15:0] idata_n, mdata_n;
    logic        mlast_n, busy_n, err_n, req_n;
    logic [31:0] tcnt, tcnt_n;
    logic [15:0] kept, len_word;
    logic [63:0] add_bits;

    assign kept = {s_keep[1] ? s_data[15:8] : 8'h00,
                   s_keep[0] ? s_data[7:0]  : 8'h00};

    // Byte count (0..2) times 8.
    assign add_bits = {59'd0, s_keep[1] & s_keep[0],
                       s_keep[1] ^ s_keep[0], 3'b000};

    // The length block reuses wcnt as its word index; words 0..3 carry bitlen.
    assign len_word = (wcnt[4:2] == 3'd0) ?
                      bitlen[{wcnt[1:0], 4'b0000} +: 16] : 16'h0000;

    assign dnext = dcnt + 4'd1;

`ifdef SIMD_FEED_DIGEST_BUF_EN
    logic [15:0] dbuf [16];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) dbuf[i] <= '0;
        end else if (state == FETCH && core_ack) begin
            dbuf[dcnt] <= core_odata;
        end
    end
`endif

    always_comb begin
        state_n  = state;
        src_n    = src;
        bitlen_n = bitlen;
        wcnt_n   = wcnt;
        dcnt_n   = dcnt;
        last_n   = last;
        idata_n  = core_idata;
        mdata_n  = m_data;
        mlast_n  = m_last;
        busy_n   = busy;
        unique case (state)
            IDLE: begin
                if (s_valid) state_n = INIT;
            end
            INIT: begin
                bitlen_n = '0;
                wcnt_n   = '0;
                dcnt_n   = '0;
                last_n   = 1'b0;
                src_n    = SRC_DATA;
                state_n  = ACCEPT;
            end
            ACCEPT: begin
                if (s_valid && s_ready) begin
                    busy_n   = 1'b1;
                    bitlen_n = bitlen + add_bits;
                    last_n   = s_last;
                    idata_n  = kept;
                    if (s_last && s_keep == 2'b00)
                        state_n = (wcnt != 5'd0) ? PAD : LEN;
                    else
                        state_n = LOAD;
                end
            end
            LOAD: begin
                if (core_ack) begin
                    wcnt_n  = wcnt + 5'd1;
                    state_n = GAP;
                end
            end
            GAP: begin
                unique case (src)
                    SRC_DATA: begin
                        if (!last)               state_n = ACCEPT;
                        else if (wcnt != 5'd0)   state_n = PAD;
                        else                     state_n = LEN;
                    end
                    SRC_PAD: state_n = (wcnt != 5'd0) ? PAD : LEN;
                    default: state_n = (wcnt != 5'd0) ? LEN : FETCH;
                endcase
            end
            PAD: begin
                src_n   = SRC_PAD;
                idata_n = 16'h0000;
                state_n = LOAD;
            end
            LEN: begin
                src_n   = SRC_LEN;
                idata_n = len_word;
                state_n = LOAD;
            end
`ifdef SIMD_FEED_DIGEST_BUF_EN
            FETCH: begin
                if (core_ack) begin
                    dcnt_n  = dnext;
                    state_n = FGAP;
                end
            end
            FGAP: begin
                // dcnt wraps to 0 once all 16 words are buffered.
                if (dcnt == 4'd0) begin
                    mdata_n = dbuf[0];
                    mlast_n = 1'b0;
                    state_n = OUT;
                end else begin
                    state_n = FETCH;
                end
            end
            OUT: begin
                if (m_valid && m_ready) begin
                    dcnt_n  = dnext;
                    mlast_n = 1'b0;
                    if (dcnt == 4'd15) begin
                        busy_n  = 1'b0;
                        state_n = IDLE;
                    end else begin
                        mdata_n = dbuf[dnext];
                        mlast_n = (dcnt == 4'd14);
                    end
                end
            end
`else
            FETCH: begin
                if (core_ack) begin
                    mdata_n = core_odata;
                    mlast_n = (dcnt == 4'd15);
                    state_n = OUT;
                end
            end
            FGAP: begin
                state_n = FETCH;
            end
            OUT: begin
                if (m_valid && m_ready) begin
                    dcnt_n  = dnext;
                    mlast_n = 1'b0;
                    if (dcnt == 4'd15) begin
                        busy_n  = 1'b0;
                        state_n = IDLE;
                    end else begin
                        state_n = FGAP;
                    end
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    // tcnt is the number of cycles the request will have been held in the
    // next cycle, so err rises in the cycle the limit is reached.
    always_comb begin
        req_n = (state_n == LOAD) || (state_n == FETCH);
        if (!req_n)
            tcnt_n = '0;
        else if (state_n != state)
            tcnt_n = 32'd1;
        else if (tcnt != '1)
            tcnt_n = tcnt + 32'd1;
        else
            tcnt_n = tcnt;
        err_n = err;
        if (ACK_TIMEOUT != 0 && req_n && tcnt_n >= 32'(ACK_TIMEOUT))
            err_n = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            src        <= SRC_DATA;
            bitlen     <= '0;
            wcnt       <= '0;
            dcnt       <= '0;
            last       <= 1'b0;
            tcnt       <= '0;
            s_ready    <= 1'b0;
            core_init  <= 1'b0;
            core_load  <= 1'b0;
            core_fetch <= 1'b0;
            core_idata <= '0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_last     <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            src        <= src_n;
            bitlen     <= bitlen_n;
            wcnt       <= wcnt_n;
            dcnt       <= dcnt_n;
            last       <= last_n;
            tcnt       <= tcnt_n;
            s_ready    <= (state_n == ACCEPT);
            core_init  <= (state_n == INIT);
            core_load  <= (state_n == LOAD);
            core_fetch <= (state_n == FETCH);
            core_idata <= idata_n;
            m_valid    <= (state_n == OUT);
            m_data     <= mdata_n;
            m_last     <= mlast_n;
            busy       <= busy_n;
            err        <= err_n;
        end
    end

endmodule

// File: tb/tb_simd_msg_feeder.sv
// tb_simd_msg_feeder: randomized scoreboard bench for simd_msg_feeder.
// A core model acks requests and supplies digest words; monitors compare.

module tb_simd_msg_feeder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] s_data;
    logic [1:0]  s_keep;
    logic        s_last, s_valid, s_ready;
    logic        core_init, core_load, core_fetch;
    logic [15:0] core_idata;
    logic        core_ack;
    logic [15:0] core_odata;
    logic [15:0] m_data;
    logic        m_valid, m_last, m_ready;
    logic        busy, err;

    simd_msg_feeder #(.ACK_TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data), .s_keep(s_keep), .s_last(s_last),
        .s_valid(s_valid), .s_ready(s_ready),
        .core_init(core_init), .core_load(core_load),
        .core_fetch(core_fetch), .core_idata(core_idata),
        .core_ack(core_ack), .core_odata(core_odata),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
        .m_ready(m_ready), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] msg[$];
    logic [15:0] exp_loads[$];
    logic [15:0] exp_m[$];

    int init_cnt, fetch_cnt, both_seen, out_total, out_base;
    bit ack_en = 1'b1;
    bit rand_dly = 1'b0;
    bit spur_ack = 1'b0;
    int ack_dly = 0;
    int rmode = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    // Core model: acks requests after a delay, supplies digest words.
    int          ccnt = 0;
    int          cdly = 0;
    logic [15:0] cfirst = '0;
    initial begin
        core_ack   = 1'b0;
        core_odata = '0;
        forever begin
            @(negedge clk);
            if (core_load && core_fetch) both_seen++;
            if (core_init) init_cnt++;
            if (core_load || core_fetch) begin
                if (ccnt == 0) begin
                    cdly = rand_dly ? int'($urandom_range(0, ack_dly)) : ack_dly;
                    cfirst = core_idata;
                end else if (core_load) begin
                    chk("idata_stable", core_idata, cfirst);
                end
                ccnt++;
                if (ack_en && ccnt > cdly) begin
                    core_ack = 1'b1;
                    if (core_load) begin
                        chk("load_expected", exp_loads.size() != 0, 1);
                        if (exp_loads.size() != 0)
                            chk("load_word", core_idata, exp_loads.pop_front());
                    end else begin
                        core_odata = 16'($urandom);
                        exp_m.push_back(core_odata);
                        fetch_cnt++;
                    end
                end else begin
                    core_ack = 1'b0;
                end
            end else begin
                ccnt = 0;
                core_ack = spur_ack ? 1'($urandom_range(0, 1)) : 1'b0;
                core_odata = 16'($urandom);
            end
        end
    end

    // Output monitor: drives m_ready, checks digest order, m_last, hold.
    bit          stalled = 1'b0;
    logic [17:0] held = '0;
    initial begin
        m_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (rmode)
                0:       m_ready = 1'b1;
                1:       m_ready = ~m_ready;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            if (stalled)
                chk("m_hold", {m_valid, m_last, m_data}, held);
            stalled = 1'b0;
            if (m_valid) begin
                if (m_ready) begin
                    chk("m_expected", exp_m.size() != 0, 1);
                    if (exp_m.size() != 0)
                        chk("m_data", m_data, exp_m.pop_front());
                    chk("m_last", m_last, (out_total % 16) == 15);
                    out_total++;
                end else begin
                    stalled = 1'b1;
                    held = {1'b1, m_last, m_data};
                end
            end
        end
    end

    // Reference: data words, zero pad to 32, then 32-word length block.
    task automatic expect_msg(input logic [1:0] lk);
        int nb = 0;
        int nl = 0;
        logic [63:0] bl;
        logic [15:0] w;
        logic [1:0]  k;
        for (int i = 0; i < msg.size(); i++) begin
            k = (i == msg.size() - 1) ? lk : 2'b11;
            w = msg[i];
            if (!k[1]) w[15:8] = 8'h00;
            if (!k[0]) w[7:0] = 8'h00;
            nb += int'(k[1]) + int'(k[0]);
            if (k != 2'b00) begin
                exp_loads.push_back(w);
                nl++;
            end
        end
        while (nl % 32 != 0) begin
            exp_loads.push_back(16'h0000);
            nl++;
        end
        bl = 64'(nb) * 64'd8;
        for (int j = 0; j < 32; j++)
            exp_loads.push_back(j < 4 ? bl[16*j +: 16] : 16'h0000);
        init_cnt = 0;
        fetch_cnt = 0;
        both_seen = 0;
        out_base = out_total;
    endtask

    task automatic drive_msg(input logic [1:0] lk);
        for (int i = 0; i < msg.size(); i++) begin
            int t = 0;
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = msg[i];
            s_last  = (i == msg.size() - 1);
            s_keep  = s_last ? lk : 2'b11;
            while (!s_ready && t < 500) begin
                @(negedge clk);
                t++;
            end
            if (!s_ready) begin
                chk("accept_timeout", s_ready, 1);
                s_valid = 1'b0;
                return;
            end
            @(posedge clk);
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("busy_during", busy, 1);
    endtask

    task automatic finish_msg();
        int t = 0;
        while (out_total < out_base + 16 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        chk("msg_done", out_total, out_base + 16);
        repeat (3) @(negedge clk);
        chk("loads_left", exp_loads.size(), 0);
        chk("digest_left", exp_m.size(), 0);
        chk("init_pulses", init_cnt, 1);
        chk("fetches", fetch_cnt, 16);
        chk("busy_after", busy, 0);
        chk("err_clear", err, 0);
        chk("load_fetch_overlap", both_seen, 0);
        exp_loads.delete();
        exp_m.delete();
    endtask

    task automatic run_msg(input logic [1:0] lk);
        expect_msg(lk);
        drive_msg(lk);
        finish_msg();
    endtask

    task automatic rand_words(input int n);
        msg.delete();
        for (int i = 0; i < n; i++) msg.push_back(16'($urandom));
    endtask

    logic [1:0] lk_tab [3] = '{2'b11, 2'b10, 2'b00};
    int k, t;

    initial begin
        rst_n = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        s_keep = 2'b11;
        s_last = 1'b0;
        out_total = 0;
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {s_ready, core_init, core_load, core_fetch, m_valid, m_last,
             busy, err, core_idata, m_data}, 40'd0);
        rst_n = 1'b1;

        msg.delete();
        msg.push_back(16'hA1B2);
        run_msg(2'b11);

        rand_words(32);
        run_msg(2'b11);

        rand_words(32);
        msg.push_back(16'h7F55);
        run_msg(2'b10);

        rand_words(1);
        run_msg(2'b00);

        ack_dly = 5;
        rmode = 1;
        for (int r = 0; r < 3; r++) begin
            rand_words(int'($urandom_range(1, 40)));
            run_msg(lk_tab[$urandom_range(0, 2)]);
        end

        rand_dly = 1'b1;
        spur_ack = 1'b1;
        rmode = 2;
        for (int r = 0; r < 3; r++) begin
            rand_words(int'($urandom_range(1, 40)));
            run_msg(lk_tab[$urandom_range(0, 2)]);
        end

        // Ack timeout followed by reset in the middle of a message.
        spur_ack = 1'b0;
        rand_dly = 1'b0;
        ack_dly = 0;
        rmode = 0;
        ack_en = 1'b0;
        msg.delete();
        msg.push_back(16'h1234);
        drive_msg(2'b11);
        k = core_load ? 1 : 0;
        t = 0;
        while (k < 8 && t < 100) begin
            @(negedge clk);
            t++;
            if (core_load) begin
                k++;
                if (k == 7) chk("err_before_timeout", err, 0);
                if (k == 8) begin
                    chk("err_at_timeout", err, 1);
                    chk("load_after_timeout", core_load, 1);
                end
            end
        end
        chk("timeout_reached", k, 8);
        rst_n = 1'b0;
        #1;
        chk("reset_mid_msg",
            {s_ready, core_init, core_load, core_fetch, m_valid, m_last,
             busy, err, core_idata, m_data}, 40'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ack_en = 1'b1;
        exp_loads.delete();
        exp_m.delete();

        rand_words(5);
        run_msg(2'b11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/simd_msg_feeder.md
# simd_msg_feeder

Upstream feeder for the SIMD-256 hash wrapper. It accepts a 16-bit message word stream and manages the wrapper's handshake: an `init` pulse per message, one `load` transaction per word, zero padding to a 512-bit block boundary and a trailing length block. After the message it issues 16 `fetch` transactions and forwards the 256-bit digest as a 16-word output stream.

## Interface
- `ACK_TIMEOUT`, default 4095: maximum cycles to wait for `core_ack` before raising `err`; 0 disables the check.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `s_data` in 16: message word; first stream byte in [15:8].
- `s_keep` in 2: 2'b11 two bytes, 2'b10 one byte ([15:8]), 2'b00 empty. The last two codes are legal only with `s_last`.
- `s_last` in 1: final word of the message.
- `s_valid` in 1: input word valid.
- `s_ready` out 1: input word accepted when `s_valid` and `s_ready` are both high.
- `core_init` out 1: one-cycle init pulse to the wrapper.
- `core_load` out 1: load request, level-held until `core_ack`.
- `core_fetch` out 1: fetch request, level-held until `core_ack`.
- `core_idata` out 16: word driven with `core_load`.
- `core_ack` in 1: wrapper acknowledge for both load and fetch.
- `core_odata` in 16: digest word, valid in the cycle `core_ack` is high during a fetch.
- `m_data` out 16: digest word.
- `m_valid` out 1: digest word valid.
- `m_last` out 1: high on the 16th digest word.
- `m_ready` in 1: downstream accepts the digest word.
- `busy` out 1: high from the first accepted word until the last digest word is accepted.
- `err` out 1: sticky ack-timeout flag; cleared only by reset.

## Operation
- States: IDLE, INIT, ACCEPT, LOAD, GAP, PAD, LEN, FETCH, FGAP, OUT.
- **IDLE**: `s_ready`=0. Moves to INIT on `s_valid`.
- **INIT**: `core_init`=1 for exactly one cycle. Clears `bitlen` (64-bit), `wcnt` (5-bit word-in-block counter) and `dcnt` (4-bit digest counter), then moves to ACCEPT.
- **ACCEPT**: `s_ready`=1 for one cycle.
  - The accepted word is captured into `hold`; bytes not enabled by `s_keep` are zeroed.
  - `bitlen` increases by 16, 8 or 0 according to `s_keep`, and `s_last` is latched.
  - An empty last word (`s_keep`=00) skips LOAD: it goes to PAD if `wcnt`≠0, otherwise to LEN.
- **LOAD**: drives `core_load`=1 with `core_idata`=`hold` until `core_ack` is sampled high. On ack, `wcnt` increments (wrapping 31→0) and the state goes to GAP.
- **GAP**: holds `core_load` low for one cycle. Next state:
  - ACCEPT if `s_last` was not latched;
  - otherwise PAD if `wcnt`≠0;
  - otherwise LEN.
- **PAD**: loads zero words through the same load/gap sequence until `wcnt` wraps to 0, then goes to LEN.
- **LEN**: loads 32 words through the load/gap sequence.
  - Words 0..3 carry `bitlen` little-endian by 16-bit word (word 0 = `bitlen`[15:0]).
  - Words 4..31 are zero.
- **FETCH** / **FGAP**: 16 transactions. Each transaction holds `core_fetch` until `core_ack`, stores `core_odata` into `dbuf[dcnt]`, then holds the request low for one cycle in FGAP.
- **OUT**: presents `dbuf` words 0..15 on `m_data` in order; `m_last` is high on word 15. After word 15 is accepted, the block returns to IDLE.
- `core_load` and `core_fetch` are never high in the same cycle.
- `core_idata` holds its value while `core_load` is high.
- `err` is set when a request is held for `ACK_TIMEOUT` cycles without ack. The request stays asserted after the timeout.
- Reset mid-message: all state is lost and the next message restarts with INIT.

## Timing
- Reset values:
  - `s_ready`, `core_init`, `core_load`, `core_fetch`, `m_valid`, `m_last`, `busy`, `err` = 0;
  - `core_idata` and `m_data` = 0;
  - state = IDLE.
- All outputs are registered.
- Minimum word cost is 3 cycles (ACCEPT, LOAD with immediate ack, GAP); core ack latency adds to this.
- Message of N full words with no stalls: 32·ceil(N/32) data/pad loads, then 32 length loads, then 16 fetches.
- `core_ack` sampled while neither request is high is ignored.
- `m_data` and `m_last` stay stable while `m_valid`=1 and `m_ready`=0.

## Configuration
- `SIMD_FEED_DIGEST_BUF_EN` defined:
  - all 16 fetches complete into `dbuf` before OUT starts;
  - output backpressure never stalls the core.
- `SIMD_FEED_DIGEST_BUF_EN` undefined:
  - there is no `dbuf`;
  - each FETCH is issued only after the previous digest word is accepted downstream;
  - `core_odata` is registered directly into `m_data`, and `m_valid` rises the cycle after ack;
  - the state interleaves FETCH → OUT(1 word) → FGAP until all 16 words are out.

## Test plan
- One word `s_data`=16'hA1B2, `s_keep`=11, `s_last` → 1 init, loads A1B2 then 31 zeros, 32 length loads with word0=16'h0010, 16 fetches, 16 `m_valid` words with `m_last` on the 16th.
- 32 full words → exactly 32 data loads and no PAD words; length word0=16'h0200, word1=0.
- 33 words, last with `s_keep`=10 and data 16'h7F55 → loaded value 16'h7F00, 31 pad words, length word0=16'h0208.
- Empty message (`s_keep`=00, `s_last`) → 0 data loads, 32 length loads all zero, 16 fetches.
- Core acks delayed 5 cycles and `m_ready` toggling every cycle → `core_idata`/`m_data` stable while held, no lost or duplicated words.
- `core_ack` held low with `ACK_TIMEOUT`=8 → `err`=1 on the 8th waiting cycle with `core_load` still 1; `rst_n` low mid-message → all outputs return to reset values.
